// File: rtl/cdb_arbiter.sv
// CDB arbiter: two skid FIFOs (ALU, LSB) feeding one registered common data bus
// through a round-robin grant, with bypass of an empty FIFO and a ROB flush.

// Small circular FIFO used once per producer; entries are {rob_id, result}.
module cdb_arbiter_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       wr,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state: flush wins over push/pop; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (wr) begin
          mem_d[wr_ptr_q] = wr_data;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr, rd})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module cdb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              wrong_commit,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [ID_W-1:0]   alu_rob_id,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [DATA_W-1:0] lsb_res,
  input  logic [ID_W-1:0]   lsb_rob_id,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_res,
  output logic [ID_W-1:0]   cdb_rob_id,
  output logic              cdb_src,
  output logic              overflow,
  output logic [15:0]       contend_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned E_W   = ID_W + DATA_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  logic [CNT_W-1:0] alu_count, lsb_count;
  logic [E_W-1:0]   alu_head, lsb_head;
  logic             alu_push, lsb_push;
  logic             alu_cand, lsb_cand;
  logic [E_W-1:0]   alu_cand_data, lsb_cand_data;
  logic             any_cand, both_cand;
  src_e             win_src;
  logic [E_W-1:0]   win_data;
  logic             advance;
  logic             alu_pop, lsb_pop, alu_wr, lsb_wr;

  logic              cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0] cdb_res_q, cdb_res_d;
  logic [ID_W-1:0]   cdb_rob_id_q, cdb_rob_id_d;
  src_e              cdb_src_q, cdb_src_d;
  src_e              last_grant_q, last_grant_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       contend_cnt_q, contend_cnt_d;

  assign alu_ready = rdy && (alu_count < CNT_W'(DEPTH));
  assign lsb_ready = rdy && (lsb_count < CNT_W'(DEPTH));

  // Accepted pushes: tag 0 is silently dropped, and a flush discards same-cycle pushes.
  assign alu_push = alu_valid && alu_ready && (alu_rob_id != '0) && !wrong_commit;
  assign lsb_push = lsb_valid && lsb_ready && (lsb_rob_id != '0) && !wrong_commit;

  // A source's candidate is its FIFO head, or the incoming push only when the FIFO is empty.
  assign alu_cand      = (alu_count != '0) || alu_push;
  assign lsb_cand      = (lsb_count != '0) || lsb_push;
  assign alu_cand_data = (alu_count != '0) ? alu_head : {alu_rob_id, alu_res};
  assign lsb_cand_data = (lsb_count != '0) ? lsb_head : {lsb_rob_id, lsb_res};
  assign advance       = rdy && !wrong_commit;

  // Round-robin grant plus FIFO pop/write decisions; a granted bypass never enters the FIFO.
  always_comb begin
    any_cand  = alu_cand || lsb_cand;
    both_cand = alu_cand && lsb_cand;
    if (both_cand) begin
      win_src = (last_grant_q == SRC_LSB) ? SRC_ALU : SRC_LSB;
    end else if (lsb_cand) begin
      win_src = SRC_LSB;
    end else begin
      win_src = SRC_ALU;
    end
    win_data = (win_src == SRC_LSB) ? lsb_cand_data : alu_cand_data;
    alu_pop  = advance && alu_cand && (win_src == SRC_ALU) && (alu_count != '0);
    lsb_pop  = advance && lsb_cand && (win_src == SRC_LSB) && (lsb_count != '0);
    alu_wr   = alu_push && !((win_src == SRC_ALU) && (alu_count == '0));
    lsb_wr   = lsb_push && !((win_src == SRC_LSB) && (lsb_count == '0));
  end

  cdb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .W     (E_W)
  ) u_alu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rdy),
    .flush   (wrong_commit),
    .wr      (alu_wr),
    .wr_data ({alu_rob_id, alu_res}),
    .rd      (alu_pop),
    .rd_data (alu_head),
    .count   (alu_count)
  );

  cdb_arbiter_fifo #(
    .DEPTH (DEPTH),
    .W     (E_W)
  ) u_lsb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rdy),
    .flush   (wrong_commit),
    .wr      (lsb_wr),
    .wr_data ({lsb_rob_id, lsb_res}),
    .rd      (lsb_pop),
    .rd_data (lsb_head),
    .count   (lsb_count)
  );

  // Output register, grant history, sticky overflow and contention counter.
  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_res_d     = cdb_res_q;
    cdb_rob_id_d  = cdb_rob_id_q;
    cdb_src_d     = cdb_src_q;
    last_grant_d  = last_grant_q;
    contend_cnt_d = contend_cnt_q;
    overflow_d    = overflow_q;
    if (rdy) begin
      overflow_d = overflow_q || (alu_valid && !alu_ready) || (lsb_valid && !lsb_ready);
      if (wrong_commit) begin
        cdb_valid_d  = 1'b0;
        last_grant_d = SRC_LSB;
      end else if (any_cand) begin
        cdb_valid_d  = 1'b1;
        cdb_res_d    = win_data[DATA_W-1:0];
        cdb_rob_id_d = win_data[E_W-1:DATA_W];
        cdb_src_d    = win_src;
        if (both_cand) begin
          last_grant_d = win_src;
          if (contend_cnt_q != '1) begin
            contend_cnt_d = contend_cnt_q + 16'd1;
          end
        end
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // Output/state flops with asynchronous clear; ALU wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q   <= 1'b0;
      cdb_res_q     <= '0;
      cdb_rob_id_q  <= '0;
      cdb_src_q     <= SRC_ALU;
      last_grant_q  <= SRC_LSB;
      overflow_q    <= 1'b0;
      contend_cnt_q <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_res_q     <= cdb_res_d;
      cdb_rob_id_q  <= cdb_rob_id_d;
      cdb_src_q     <= cdb_src_d;
      last_grant_q  <= last_grant_d;
      overflow_q    <= overflow_d;
      contend_cnt_q <= contend_cnt_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_res     = cdb_res_q;
  assign cdb_rob_id  = cdb_rob_id_q;
  assign cdb_src     = cdb_src_q;
  assign overflow    = overflow_q;
  assign contend_cnt = contend_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table plus scoreboarded multi-cycle sequences.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        wrong_commit;
  logic        alu_valid;
  logic [31:0] alu_res;
  logic [4:0]  alu_rob_id;
  logic        alu_ready;
  logic        lsb_valid;
  logic [31:0] lsb_res;
  logic [4:0]  lsb_rob_id;
  logic        lsb_ready;
  logic        cdb_valid;
  logic [31:0] cdb_res;
  logic [4:0]  cdb_rob_id;
  logic        cdb_src;
  logic        overflow;
  logic [15:0] contend_cnt;

  cdb_arbiter #(
    .DEPTH  (4),
    .DATA_W (32),
    .ID_W   (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .wrong_commit (wrong_commit),
    .alu_valid    (alu_valid),
    .alu_res      (alu_res),
    .alu_rob_id   (alu_rob_id),
    .alu_ready    (alu_ready),
    .lsb_valid    (lsb_valid),
    .lsb_res      (lsb_res),
    .lsb_rob_id   (lsb_rob_id),
    .lsb_ready    (lsb_ready),
    .cdb_valid    (cdb_valid),
    .cdb_res      (cdb_res),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_src      (cdb_src),
    .overflow     (overflow),
    .contend_cnt  (contend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  id;
  } sb_t;

  sb_t  alu_q[$];
  sb_t  lsb_q[$];
  logic sb_on = 1'b0;
  logic [31:0] last_res;
  logic [4:0]  last_id;

  typedef struct {
    logic        av;
    logic [31:0] ares;
    logic [4:0]  aid;
    logic        lv;
    logic [31:0] lres;
    logic [4:0]  lid;
    logic        wc;
    logic        r;
    logic        e_ar;
    logic        e_lr;
    logic        e_v;
    logic [31:0] e_res;
    logic [4:0]  e_id;
    logic        e_src;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pops the scoreboard queue of the reported source and compares the broadcast.
  task automatic sb_check();
    sb_t e;
    if (cdb_valid) begin
      if ((cdb_src == 1'b0 && alu_q.size() == 0) || (cdb_src == 1'b1 && lsb_q.size() == 0)) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected: got src %0d id %0h expected no broadcast", cdb_src, cdb_rob_id);
      end else begin
        e = (cdb_src == 1'b0) ? alu_q.pop_front() : lsb_q.pop_front();
        chk("sb_id", cdb_rob_id, e.id);
        chk("sb_res", cdb_res, e.res);
        last_res = e.res;
        last_id  = e.id;
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, record accepted pushes, sample after the edge.
  task automatic step(input logic av, input logic [31:0] ares, input logic [4:0] aid,
                      input logic lv, input logic [31:0] lres, input logic [4:0] lid,
                      input logic wc, input logic r,
                      output logic a_acc, output logic l_acc, output logic a_r, output logic l_r);
    alu_valid    = av;
    alu_res      = ares;
    alu_rob_id   = aid;
    lsb_valid    = lv;
    lsb_res      = lres;
    lsb_rob_id   = lid;
    wrong_commit = wc;
    rdy          = r;
    #1;
    a_r   = alu_ready;
    l_r   = lsb_ready;
    a_acc = r && av && a_r && (aid != 5'd0) && !wc;
    l_acc = r && lv && l_r && (lid != 5'd0) && !wc;
    if (sb_on && a_acc) alu_q.push_back('{res: ares, id: aid});
    if (sb_on && l_acc) lsb_q.push_back('{res: lres, id: lid});
    @(posedge clk);
    @(negedge clk);
    if (sb_on && r) sb_check();
  endtask

  task automatic idle();
    logic a, b, c, d;
    step(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, a, b, c, d);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    rdy          = 1'b1;
    wrong_commit = 1'b0;
    alu_valid    = 1'b0;
    lsb_valid    = 1'b0;
    alu_res      = '0;
    lsb_res      = '0;
    alu_rob_id   = '0;
    lsb_rob_id   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    alu_q.delete();
    lsb_q.delete();
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && (alu_q.size() != 0 || lsb_q.size() != 0); k++) idle();
    chk({nm, "_alu_q_empty"}, alu_q.size(), 0);
    chk({nm, "_lsb_q_empty"}, lsb_q.size(), 0);
    idle();
    chk({nm, "_idle_valid"}, cdb_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic aa, la, ar, lr;
    int   aid, lid;
    logic saw_full;

    //        av ares        aid  lv lres        lid  wc r   ear elr ev e_res        e_id e_src e_cnt
    tbl[0]  = '{0, 32'h0,    5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 0, 32'h0,     5'd0, 0, 16'd0};
    tbl[1]  = '{1, 32'h1234, 5'd3, 0, 32'h0,    5'd0, 0, 1,  1, 1, 1, 32'h1234,  5'd3, 0, 16'd0};
    tbl[2]  = '{0, 32'h0,    5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 0, 32'h1234,  5'd3, 0, 16'd0};
    tbl[3]  = '{1, 32'hA,    5'd1, 1, 32'hB,    5'd2, 0, 1,  1, 1, 1, 32'hA,     5'd1, 0, 16'd1};
    tbl[4]  = '{0, 32'h0,    5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 1, 32'hB,     5'd2, 1, 16'd1};
    tbl[5]  = '{1, 32'hC,    5'd4, 1, 32'hD,    5'd5, 0, 1,  1, 1, 1, 32'hD,     5'd5, 1, 16'd2};
    tbl[6]  = '{0, 32'h0,    5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 1, 32'hC,     5'd4, 0, 16'd2};
    tbl[7]  = '{1, 32'h99,   5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 0, 32'hC,     5'd4, 0, 16'd2};
    tbl[8]  = '{1, 32'h98,   5'd0, 1, 32'h97,   5'd0, 0, 1,  1, 1, 0, 32'hC,     5'd4, 0, 16'd2};
    tbl[9]  = '{1, 32'h66,   5'd6, 0, 32'h0,    5'd0, 0, 0,  0, 0, 0, 32'hC,     5'd4, 0, 16'd2};
    tbl[10] = '{0, 32'h0,    5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 0, 32'hC,     5'd4, 0, 16'd2};
    tbl[11] = '{1, 32'h9,    5'd9, 1, 32'h8,    5'd8, 1, 1,  1, 1, 0, 32'hC,     5'd4, 0, 16'd2};
    tbl[12] = '{0, 32'h0,    5'd0, 0, 32'h0,    5'd0, 0, 1,  1, 1, 0, 32'hC,     5'd4, 0, 16'd2};

    do_reset();
    #1;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_res", cdb_res, 32'h0);
    chk("rst_id", cdb_rob_id, 5'd0);
    chk("rst_src", cdb_src, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_contend", contend_cnt, 16'd0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_lsb_ready", lsb_ready, 1'b1);
    @(negedge clk);

    // Directed vectors: single result, tie round-robin, tag 0, rdy low, flush.
    sb_on = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].av, tbl[i].ares, tbl[i].aid, tbl[i].lv, tbl[i].lres, tbl[i].lid,
           tbl[i].wc, tbl[i].r, aa, la, ar, lr);
      chk($sformatf("vec%0d_alu_ready", i), ar, tbl[i].e_ar);
      chk($sformatf("vec%0d_lsb_ready", i), lr, tbl[i].e_lr);
      chk($sformatf("vec%0d_valid", i), cdb_valid, tbl[i].e_v);
      chk($sformatf("vec%0d_res", i), cdb_res, tbl[i].e_res);
      chk($sformatf("vec%0d_id", i), cdb_rob_id, tbl[i].e_id);
      chk($sformatf("vec%0d_src", i), cdb_src, tbl[i].e_src);
      chk($sformatf("vec%0d_contend", i), contend_cnt, tbl[i].e_cnt);
    end
    chk("vec_overflow_clear", overflow, 1'b0);

    // Fill and back-pressure: LSB pushes every cycle, ALU pushes ids 1..9 retrying when not ready.
    do_reset();
    @(negedge clk);
    sb_on    = 1'b1;
    saw_full = 1'b0;
    aid      = 1;
    lid      = 16;
    for (int c = 0; c < 40 && aid <= 9; c++) begin
      step(1'b1, 32'h100 + 32'(aid), 5'(aid), 1'b1, 32'h200 + 32'(lid), 5'(lid),
           1'b0, 1'b1, aa, la, ar, lr);
      if (!ar) saw_full = 1'b1;
      if (aa) aid++;
      if (la) lid = (lid == 31) ? 16 : lid + 1;
    end
    chk("fill_all_alu_accepted", aid, 10);
    chk("fill_alu_ready_dropped", saw_full, 1'b1);
    chk("fill_overflow", overflow, 1'b1);
    drain("fill");

    // Asynchronous reset between clock edges while a broadcast is on the bus.
    step(1'b1, 32'h5A5A, 5'd3, 1'b1, 32'hA5A5, 5'd17, 1'b0, 1'b1, aa, la, ar, lr);
    chk("arst_pre_valid", cdb_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", cdb_valid, 1'b0);
    chk("arst_res", cdb_res, 32'h0);
    chk("arst_id", cdb_rob_id, 5'd0);
    chk("arst_src", cdb_src, 1'b0);
    chk("arst_overflow", overflow, 1'b0);
    chk("arst_contend", contend_cnt, 16'd0);
    alu_q.delete();
    lsb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Flush: queue entries from both sources, then wrong_commit with a same-cycle push.
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 32'h300 + 32'(c), 5'(c + 1), 1'b1, 32'h400 + 32'(c), 5'(c + 17),
           1'b0, 1'b1, aa, la, ar, lr);
    end
    chk("flush_pending", alu_q.size() + lsb_q.size(), 5);
    step(1'b1, 32'h777, 5'd30, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, aa, la, ar, lr);
    alu_q.delete();
    lsb_q.delete();
    chk("flush_valid", cdb_valid, 1'b0);
    chk("flush_alu_ready", alu_ready, 1'b1);
    chk("flush_lsb_ready", lsb_ready, 1'b1);
    chk("flush_contend_kept", contend_cnt, 16'd5);
    step(1'b1, 32'h7777, 5'd7, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, aa, la, ar, lr);
    chk("flush_new_valid", cdb_valid, 1'b1);
    chk("flush_new_id", cdb_rob_id, 5'd7);
    repeat (3) idle();
    drain("flush");

    // rdy stall with entries queued; pushes offered while stalled must be ignored.
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 32'h500 + 32'(c), 5'(c + 1), 1'b1, 32'h600 + 32'(c), 5'(c + 17),
           1'b0, 1'b1, aa, la, ar, lr);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 32'h999, 5'd9, 1'b1, 32'h888, 5'd8, 1'b0, 1'b0, aa, la, ar, lr);
      chk("stall_alu_ready", ar, 1'b0);
      chk("stall_lsb_ready", lr, 1'b0);
      chk("stall_valid_held", cdb_valid, 1'b1);
      chk("stall_id_held", cdb_rob_id, last_id);
      chk("stall_res_held", cdb_res, last_res);
      chk("stall_contend_held", contend_cnt, 16'd3);
    end
    chk("stall_overflow", overflow, 1'b0);
    drain("stall");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
